// File: rtl/cplx_pkg.sv
// cplx_pkg: shared widths, FSM state type and saturating clamp for the
// complex-product accumulator.
//   NIB_W   : width of one signed product part (real or imaginary)
//   PART_W  : width of one packed complex product {re, im}
//   state_t : accumulator FSM states
//   sat_clamp : clamp a (PART_W+1)-bit signed sum to a w-bit signed range
package cplx_pkg;

    localparam int NIB_W  = 8;
    localparam int PART_W = 16;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,   // taking products
        HOLD  = 1'b1    // result presented, waiting for downstream
    } state_t;

    // Clamp s into [-2^(w-1), 2^(w-1)-1]; sat reports that clamping occurred.
    // The return value carries the clamped number in its low w bits.
    function automatic logic [PART_W-1:0] sat_clamp(
        input  logic signed [PART_W:0] s,
        input  int                     w,
        output logic                   sat
    );
        logic signed [PART_W:0] hi;
        logic signed [PART_W:0] lo;
        hi  = (17'sd1 <<< (w - 1)) - 17'sd1;
        lo  = -hi - 17'sd1;
        sat = 1'b0;
        if (s > hi) begin
            sat       = 1'b1;
            sat_clamp = hi[PART_W-1:0];
        end else if (s < lo) begin
            sat       = 1'b1;
            sat_clamp = lo[PART_W-1:0];
        end else begin
            sat_clamp = s[PART_W-1:0];
        end
    endfunction

endpackage

// File: rtl/cmul_accumulator_sat_add.sv
// sat_add: signed NIB_W-bit part plus signed ACC_W-bit accumulator with
// saturation to the ACC_W range.
//   part : signed product component
//   acc  : current accumulator value
//   sum  : clamped acc + part
//   sat  : sum was clamped
module sat_add
    import cplx_pkg::*;
#(
    parameter int ACC_W = 12
) (
    input  logic signed [NIB_W-1:0] part,
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [ACC_W-1:0] sum,
    output logic                    sat
);

    logic signed [ACC_W:0] raw;
    logic [PART_W-1:0]     clamped;
    logic                  clip;

    always_comb begin
        // One extra bit holds any single add exactly; the clamp folds it back.
        raw     = (ACC_W + 1)'(part) + (ACC_W + 1)'(acc);
        clip    = 1'b0;
        clamped = sat_clamp((PART_W + 1)'(raw), ACC_W, clip);
        sum     = ACC_W'(clamped);
        sat     = clip;
    end

endmodule

// File: rtl/cmul_accumulator.sv
// cmul_accumulator: sums N_TERMS packed complex products into saturating
// real/imaginary accumulators and presents each finished sum on a
// valid/ready port. A one-entry skid catches a product arriving while a
// result is still waiting for acceptance.
//   clk, rst   : clock, asynchronous active-low reset
//   in_valid   : one-cycle pulse, product on in_data = {re[7:0], im[7:0]}
//   clear      : synchronous frame abort (overflow survives)
//   out_valid/out_ready : result handshake
//   out_data   : {re[ACC_W-1:0], im[ACC_W-1:0]}
//   out_sat    : some clamp happened in this frame (qualified by out_valid)
//   overflow   : sticky, a product was dropped
//   busy       : partial frame, pending result or occupied skid
module cmul_accumulator
    import cplx_pkg::*;
#(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [PART_W-1:0]    in_data,
    input  logic                 clear,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*ACC_W-1:0]   out_data,
    output logic                 out_sat,
    output logic                 overflow,
    output logic                 busy
);

    state_t                  state;
    logic [3:0]              count;
    logic signed [ACC_W-1:0] acc_re;
    logic signed [ACC_W-1:0] acc_im;
    logic signed [ACC_W-1:0] sum_re;
    logic signed [ACC_W-1:0] sum_im;
    logic                    sat_re;
    logic                    sat_im;
    logic                    frame_sat;
    logic                    skid_vld;
    logic [PART_W-1:0]       skid_data;
    logic [PART_W-1:0]       prod;
    logic                    consume;
    logic                    last;

    // The skid always holds the oldest product, so it is drained first.
    always_comb begin
        consume = (state == ACCUM) && (skid_vld || in_valid);
        prod    = skid_vld ? skid_data : in_data;
        last    = consume && (count == 4'(N_TERMS - 1));
    end

    sat_add #(.ACC_W(ACC_W)) u_add_re (
        .part (prod[15:8]),
        .acc  (acc_re),
        .sum  (sum_re),
        .sat  (sat_re)
    );

    sat_add #(.ACC_W(ACC_W)) u_add_im (
        .part (prod[7:0]),
        .acc  (acc_im),
        .sum  (sum_im),
        .sat  (sat_im)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ACCUM;
            count     <= '0;
            acc_re    <= '0;
            acc_im    <= '0;
            frame_sat <= 1'b0;
            skid_vld  <= 1'b0;
            skid_data <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            overflow  <= 1'b0;
        end else if (clear) begin
            state     <= ACCUM;
            count     <= '0;
            acc_re    <= '0;
            acc_im    <= '0;
            frame_sat <= 1'b0;
            skid_vld  <= 1'b0;
            out_valid <= 1'b0;
            out_sat   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (consume) begin
                        if (last) begin
                            out_data  <= {sum_re, sum_im};
                            out_sat   <= frame_sat | sat_re | sat_im;
                            out_valid <= 1'b1;
                            count     <= '0;
                            acc_re    <= '0;
                            acc_im    <= '0;
                            frame_sat <= 1'b0;
                            state     <= HOLD;
                        end else begin
                            acc_re    <= sum_re;
                            acc_im    <= sum_im;
                            frame_sat <= frame_sat | sat_re | sat_im;
                            count     <= count + 4'd1;
                        end
                    end
                    // Skid drained this cycle; a new pulse refills it behind.
                    // With the skid empty, a pulse is consumed directly.
                    if (skid_vld) begin
                        skid_vld <= in_valid;
                        if (in_valid) skid_data <= in_data;
                    end
                end
                HOLD: begin
                    if (in_valid) begin
                        if (!skid_vld) begin
                            skid_vld  <= 1'b1;
                            skid_data <= in_data;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                    // out_valid is always set while in HOLD.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_sat   <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign busy = (count != 4'd0) || out_valid || skid_vld;

endmodule

// File: tb/tb_cmul_accumulator.sv
// tb_cmul_accumulator: directed checks of cmul_accumulator in three
// configurations sharing one stimulus stream: (4,12), (4,9) and (1,12).
module tb_cmul_accumulator;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        clear;
    logic        out_ready;

    logic        ov_a, os_a, of_a, bz_a;
    logic [23:0] od_a;
    logic        ov_9, os_9, of_9, bz_9;
    logic [17:0] od_9;
    logic        ov_1, os_1, of_1, bz_1;
    logic [23:0] od_1;

    int n_tests = 0;
    int n_fail  = 0;

    cmul_accumulator #(.N_TERMS(4), .ACC_W(12)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .clear(clear), .out_valid(ov_a), .out_ready(out_ready),
        .out_data(od_a), .out_sat(os_a), .overflow(of_a), .busy(bz_a)
    );

    cmul_accumulator #(.N_TERMS(4), .ACC_W(9)) dut9 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .clear(clear), .out_valid(ov_9), .out_ready(out_ready),
        .out_data(od_9), .out_sat(os_9), .overflow(of_9), .busy(bz_9)
    );

    cmul_accumulator #(.N_TERMS(1), .ACC_W(12)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .clear(clear), .out_valid(ov_1), .out_ready(out_ready),
        .out_data(od_1), .out_sat(os_1), .overflow(of_1), .busy(bz_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Starts and ends on a falling edge; the product is taken at the rising edge between.
    task automatic pulse(input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = '0; clear = 1'b0; out_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("rst_valid", 32'(ov_a), 32'd0);
        chk("rst_data",  32'(od_a), 32'd0);
        chk("rst_sat",   32'(os_a), 32'd0);
        chk("rst_busy",  32'(bz_a), 32'd0);
        chk("rst_ovf",   32'(of_a), 32'd0);
        rst = 1'b1;

        // basic sum: 4 x (+3, -2)
        pulse(16'h03FE); pulse(16'h03FE);
        chk("basic_busy", 32'(bz_a), 32'd1);
        chk("basic_early", 32'(ov_a), 32'd0);
        pulse(16'h03FE); pulse(16'h03FE);
        chk("basic_valid", 32'(ov_a), 32'd1);
        chk("basic_data",  32'(od_a), 32'({12'h00C, 12'hFF8}));
        chk("basic_sat",   32'(os_a), 32'd0);
        @(negedge clk);
        chk("basic_1cyc",  32'(ov_a), 32'd0);
        chk("basic_idle",  32'(bz_a), 32'd0);

        // saturation at ACC_W=9: 4 x (127, -128)
        do_reset();
        repeat (4) pulse(16'h7F80);
        chk("sat_valid", 32'(ov_9), 32'd1);
        chk("sat_data",  32'(od_9), 32'({9'h0FF, 9'h100}));
        chk("sat_flag",  32'(os_9), 32'd1);
        @(negedge clk);
        chk("sat_flag_clr", 32'(os_9), 32'd0);
        repeat (4) pulse(16'h0101);
        chk("sat_next_data", 32'(od_9), 32'({9'd4, 9'd4}));
        chk("sat_next_flag", 32'(os_9), 32'd0);
        @(negedge clk);

        // back-pressure: skid fill, then drop
        do_reset();
        out_ready = 1'b0;
        repeat (4) pulse(16'h03FE);
        chk("bp_valid", 32'(ov_a), 32'd1);
        pulse(16'h0101);
        chk("bp_hold_data", 32'(od_a), 32'({12'h00C, 12'hFF8}));
        chk("bp_hold_valid", 32'(ov_a), 32'd1);
        chk("bp_no_ovf", 32'(of_a), 32'd0);
        pulse(16'h0202);
        chk("bp_ovf", 32'(of_a), 32'd1);
        chk("bp_hold_data2", 32'(od_a), 32'({12'h00C, 12'hFF8}));
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_accept", 32'(ov_a), 32'd0);
        // skid (1,1) then 3 x (2,3) -> (7,10)
        repeat (3) pulse(16'h0203);
        @(negedge clk);
        chk("bp_next_valid", 32'(ov_a), 32'd1);
        chk("bp_next_data",  32'(od_a), 32'({12'd7, 12'd10}));
        chk("bp_ovf_sticky", 32'(of_a), 32'd1);
        @(negedge clk);

        // clear colliding with in_valid at count 2
        do_reset();
        pulse(16'h0101); pulse(16'h0101);
        clear = 1'b1; in_valid = 1'b1; in_data = 16'h7F7F;
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        chk("clr_busy",  32'(bz_a), 32'd0);
        chk("clr_valid", 32'(ov_a), 32'd0);
        repeat (3) pulse(16'h0203);
        chk("clr_not_yet", 32'(ov_a), 32'd0);
        pulse(16'h0203);
        chk("clr_valid2", 32'(ov_a), 32'd1);
        chk("clr_data",   32'(od_a), 32'({12'd8, 12'd12}));
        @(negedge clk);

        // asynchronous reset with result pending, skid full, overflow set
        out_ready = 1'b0;
        repeat (4) pulse(16'h03FE);
        pulse(16'h0101);
        pulse(16'h0202);
        chk("ar_pre_ovf",   32'(of_a), 32'd1);
        chk("ar_pre_valid", 32'(ov_a), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("ar_valid", 32'(ov_a), 32'd0);
        chk("ar_data",  32'(od_a), 32'd0);
        chk("ar_sat",   32'(os_a), 32'd0);
        chk("ar_ovf",   32'(of_a), 32'd0);
        chk("ar_busy",  32'(bz_a), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;

        // N_TERMS=1, back-to-back pairs
        in_valid = 1'b1; in_data = 16'h0101;
        @(negedge clk);
        chk("n1_a_valid", 32'(ov_1), 32'd1);
        chk("n1_a_data",  32'(od_1), 32'({12'd1, 12'd1}));
        in_data = 16'h0202;
        @(negedge clk);
        in_valid = 1'b0;
        chk("n1_a_gap", 32'(ov_1), 32'd0);
        @(negedge clk);
        chk("n1_b_valid", 32'(ov_1), 32'd1);
        chk("n1_b_data",  32'(od_1), 32'({12'd2, 12'd2}));
        @(negedge clk);
        chk("n1_b_done", 32'(ov_1), 32'd0);
        chk("n1_idle",   32'(bz_1), 32'd0);
        in_valid = 1'b1; in_data = 16'h7F80;
        @(negedge clk);
        chk("n1_c_data", 32'(od_1), 32'({12'd127, 12'hF80}));
        in_data = 16'h0005;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("n1_d_valid", 32'(ov_1), 32'd1);
        chk("n1_d_data",  32'(od_1), 32'({12'd0, 12'd5}));
        chk("n1_ovf",     32'(of_1), 32'd0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cmul_accumulator.md
# cmul_accumulator

Downstream consumer of the complex multiplier stage. Takes each packed complex product, one single-cycle `in_valid` pulse per product (the multiplier's `is_done`), and accumulates it into saturating real and imaginary sums. After `N_TERMS` products it presents the finished complex sum on a valid/ready output toward writeback. A one-entry skid register absorbs a product that arrives while a finished result is still waiting for acceptance.

## Interface
- `N_TERMS`, default 4: number of products summed per result; legal values 1 to 15.
- `ACC_W`, default 12: width of each signed accumulator component; legal values 9 to 16.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: one-cycle pulse, new product on `in_data`.
- `in_data`  in  16: `[15:8]` signed real part, `[7:0]` signed imaginary part.
- `clear`  in  1: synchronous frame abort.
- `out_valid`  out  1: finished sum available.
- `out_ready`  in  1: downstream accepts the result.
- `out_data`  out  2*ACC_W: `{re[ACC_W-1:0], im[ACC_W-1:0]}`, two's complement.
- `out_sat`  out  1: at least one component saturated during this frame; qualified by `out_valid`.
- `overflow`  out  1: sticky flag, set when a product was dropped.
- `busy`  out  1: `count != 0`, or `out_valid`, or skid occupied.

## Operation
- State machine has two states.
  - ACCUM: accept products.
  - HOLD: result presented, waiting for handshake.
- Reset values: state ACCUM, `count`=0, accumulators 0, skid empty, `out_valid`=0, `out_data`=0, `out_sat`=0, `overflow`=0.
- Product source in ACCUM:
  - Skid occupied: consume the skid. A concurrent `in_valid` is written into the skid in the same cycle.
  - Skid empty: consume `in_data` when `in_valid`=1.
- Accumulation:
  - Each 8-bit part is sign-extended to ACC_W+1 bits and added to its accumulator.
  - Each result is clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Any clamp sets the frame's sticky saturation bit.
- Frame completion: consuming a product with `count`==N_TERMS-1 does the following at the same edge:
  - registers the saturated sums into `out_data` and the sticky bit into `out_sat`;
  - sets `out_valid`=1;
  - resets `count` to 0 and the accumulators to 0;
  - enters HOLD.
- HOLD:
  - `out_data` and `out_sat` stay stable.
  - An `in_valid` goes to the skid if the skid is empty. Otherwise the product is dropped and `overflow` is set.
  - `out_valid && out_ready` at an edge clears `out_valid` and `out_sat` and returns to ACCUM.
- `clear`=1 has priority over everything else and produces ACCUM, `count`=0, accumulators 0, skid empty, `out_valid`=0. The `in_valid` in that same cycle is discarded. `overflow` is not cleared; only reset clears it.
- Reset mid-frame discards all partial state immediately (asynchronous).

## Timing
- `in_valid` at cycle t in ACCUM: accumulators updated at the end of t.
- Last term at cycle t: `out_valid`=1 from cycle t+1.
- Handshake at edge k: `out_valid`=0 from cycle k+1. A skid entry is consumed in cycle k+1, so it is added at edge k+1.
- Throughput: one product per cycle in ACCUM. HOLD costs at least 1 cycle per frame.
- With N_TERMS=1, every consumed product produces a result. Back-to-back pulses then rely on the skid.
- No combinational path from `out_ready` to `out_valid` or `out_data`. No combinational path from inputs to any output.

## Structure
- Package `cplx_pkg` contains:
  - the nibble and part widths (8 and 16);
  - the state enum {ACCUM, HOLD};
  - the function `sat_clamp` (ACC_W+1 bits to ACC_W bits, returns a saturation flag).
- Sub-module `sat_add`: one signed 8-bit plus ACC_W saturating adder with a saturation output. It is instantiated twice, once for real and once for imaginary.
- The FSM, counter and skid live in the top-level `cmul_accumulator`.

## Test plan
- Basic sum. N_TERMS=4, ACC_W=12. Four pulses of 16'h03FE (re=+3, im=-2), `out_ready`=1 -> `out_data`={12'h00C, 12'hFF8}, `out_sat`=0, `out_valid` high for exactly 1 cycle.
- Saturation. ACC_W=9. Four pulses of 16'h7F80 (re=127, im=-128) -> re=255, im=-256, i.e. {9'h0FF, 9'h100}, `out_sat`=1. The next frame's `out_sat` returns to 0.
- Back-pressure. Hold `out_ready`=0 after a frame completes.
  - Send 16'h0101 -> skid occupied, `out_data` unchanged.
  - Send a second pulse -> `overflow`=1.
  - Raise `out_ready` -> the next frame's first term is re=1, im=1.
- Clear collision. Assert `clear` together with `in_valid` mid-frame (`count`=2) -> `count`=0, accumulators 0. The next 4 products alone form the result.
- Reset mid-frame. Drop `rst` after 2 products with `out_valid` pending -> all outputs at reset values immediately, asynchronous with no clock edge needed.
- N_TERMS=1 with back-to-back pulses -> every product is emitted with no loss, and `overflow` stays 0 under `out_ready`=1.
